// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N byte-stream requesters.
// A packet lock keeps multi-byte messages contiguous; a busy timeout drops a stalled byte.
module uart_tx_sched #(
    parameter int unsigned N       = 2,
    parameter logic [15:0] GAP_CYC = 16'd0,
    parameter logic [7:0]  BUSY_TO = 8'd16
) (
    input  logic           sysclk_i,
    input  logic           rst_b_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic [N-1:0]   active_o,
    output logic           tx_start_o,
    output logic [7:0]     tx_data_o,
    input  logic           tx_busy_i,
    output logic           err_to_o
);

    // state     | meaning
    // IDLE      | arbitrate and accept a byte
    // START     | one-cycle tx_start pulse
    // WAIT_BUSY | wait for tx_busy to rise, bounded by BUSY_TO
    // WAIT_DONE | wait for tx_busy to fall
    // GAP       | inter-frame idle cycles
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_e;

    localparam int unsigned GW        = (N > 2) ? 2 : 1;
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TO) - 16'd1;
    localparam logic [15:0] GAP_LAST  = GAP_CYC - 16'd1;

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] v);
        return (int'(v) == int'(N) - 1) ? '0 : v + GW'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [GW-1:0] v);
        return {{(N-1){1'b0}}, 1'b1} << v;
    endfunction

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [GW-1:0] lock_id_q, lock_id_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [N-1:0]  active_q, active_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          err_to_q, err_to_d;

    logic [GW-1:0] cand;
    logic [GW-1:0] grant_idx;
    logic          grant_ok;

    // A held lock restricts eligibility to its owner; otherwise search upward from ptr_q.
    always_comb begin
        cand      = ptr_q;
        grant_ok  = 1'b0;
        grant_idx = ptr_q;
        if (lock_q) begin
            grant_ok  = req_valid_i[lock_id_q];
            grant_idx = lock_id_q;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (!grant_ok && req_valid_i[cand]) begin
                    grant_ok  = 1'b1;
                    grant_idx = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        owner_d     = owner_q;
        active_d    = active_q;
        tx_data_d   = tx_data_q;
        err_to_d    = 1'b0;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    req_ready_o = onehot(grant_idx);
                    tx_data_d   = req_data_i[{grant_idx, 3'b000} +: 8];
                    active_d    = onehot(grant_idx);
                    owner_d     = grant_idx;
                    if (req_last_i[grant_idx]) begin
                        lock_d = 1'b0;
                        ptr_d  = next_idx(grant_idx);
                    end else begin
                        lock_d    = 1'b1;
                        lock_id_d = grant_idx;
                    end
                    state_d = START;
                end
            end
            START: begin
                tx_start_o = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == BUSY_LAST) begin
                    err_to_d = 1'b1;
                    lock_d   = 1'b0;
                    ptr_d    = next_idx(owner_q);
                    active_d = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    cnt_d = '0;
                    if (GAP_CYC != 16'd0) begin
                        state_d = GAP;
                    end else begin
                        active_d = lock_q ? active_q : '0;
                        state_d  = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    active_d = lock_q ? active_q : '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            owner_q   <= '0;
            active_q  <= '0;
            tx_data_q <= 8'h00;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            owner_q   <= owner_d;
            active_q  <= active_d;
            tx_data_q <= tx_data_d;
            err_to_q  <= err_to_d;
        end
    end

    assign active_o  = active_q;
    assign tx_data_o = tx_data_q;
    assign err_to_o  = err_to_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a no-gap instance for arbitration, lock, timeout and reset,
// and a GAP_CYC=100 instance for inter-frame spacing.
module tb_uart_tx_sched;

    localparam int B_LEN = 10;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [1:0]  active;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        err_to;

    logic [1:0]  b_valid = '0;
    logic [15:0] b_data = 16'h0077;
    logic [1:0]  b_last = 2'b11;
    logic [1:0]  b_ready;
    logic [1:0]  b_active;
    logic        b_start;
    logic [7:0]  b_tx_data;
    logic        b_busy = 1'b0;
    logic        b_err;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    uart_tx_sched #(.N(2), .GAP_CYC(16'd0), .BUSY_TO(8'd16)) u_dut (
        .sysclk_i(clk), .rst_b_i(rst_b),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .active_o(active),
        .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .err_to_o(err_to)
    );

    uart_tx_sched #(.N(2), .GAP_CYC(16'd100), .BUSY_TO(8'd16)) u_dut_gap (
        .sysclk_i(clk), .rst_b_i(rst_b),
        .req_valid_i(b_valid), .req_data_i(b_data), .req_last_i(b_last),
        .req_ready_o(b_ready), .active_o(b_active),
        .tx_start_o(b_start), .tx_data_o(b_tx_data),
        .tx_busy_i(b_busy), .err_to_o(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // requester queues hold {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int         cyc = 0;
    bit         busy_en = 1'b1;
    int         busy_dly = 3;
    int         busy_len = 20;
    int         rise_at = 0;
    int         fall_at = 0;
    int         acc_cyc[$];
    logic [1:0] acc_vec[$];
    int         start_cyc[$];
    logic [7:0] start_data[$];
    int         err_cyc[$];
    logic [1:0] err_active[$];
    int         err_total = 0;
    int         bad_txd = 0;
    int         bad_ready = 0;
    logic [1:0] acc_pop = '0;
    logic [7:0] prev_txd = '0;
    bit         prev_acc = 1'b0;
    bit         prev_rst_b = 1'b1;

    bit         b_en = 1'b0;
    int         b_rise = 0;
    int         b_fall = 0;
    int         b_acc[$];
    int         b_start_cyc[$];
    logic [7:0] b_start_data[$];
    int         b_fall_log[$];
    int         b_err_cnt = 0;

    // Monitor samples at the falling edge; requester and transmitter models drive just after the rising edge.
    always begin
        @(negedge clk);
        acc_pop = req_ready;
        if (req_ready != 2'b00) begin
            acc_cyc.push_back(cyc);
            acc_vec.push_back(req_ready);
        end
        if ($countones(req_ready) > 1) bad_ready++;
        if (tx_start) begin
            start_cyc.push_back(cyc);
            start_data.push_back(tx_data);
            rise_at = cyc + busy_dly;
            fall_at = rise_at + busy_len;
        end
        if (err_to) begin
            err_cyc.push_back(cyc);
            err_active.push_back(active);
            err_total++;
        end
        if (rst_b && prev_rst_b && tx_data != prev_txd && !prev_acc) bad_txd++;
        prev_txd   = tx_data;
        prev_acc   = (req_ready != 2'b00);
        prev_rst_b = rst_b;

        if (b_ready != 2'b00) b_acc.push_back(cyc);
        if (b_start) begin
            b_start_cyc.push_back(cyc);
            b_start_data.push_back(b_tx_data);
            b_rise = cyc + 1;
            b_fall = cyc + 1 + B_LEN;
            b_fall_log.push_back(b_fall);
        end
        if (b_err) b_err_cnt++;

        @(posedge clk);
        #1;
        cyc++;
        if (acc_pop[0] && q0.size() > 0) q0.delete(0);
        if (acc_pop[1] && q1.size() > 0) q1.delete(0);
        req_valid[0]   = (q0.size() > 0);
        req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req_valid[1]   = (q1.size() > 0);
        req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        tx_busy        = busy_en && (cyc >= rise_at) && (cyc < fall_at);
        b_valid[0]     = b_en && (b_acc.size() < 3);
        b_busy         = (cyc >= b_rise) && (cyc < b_fall);
    end

    task automatic clear_logs();
        acc_cyc.delete();
        acc_vec.delete();
        start_cyc.delete();
        start_data.delete();
        err_cyc.delete();
        err_active.delete();
    endtask

    task automatic wait_starts(input int n, input int limit);
        for (int i = 0; i < limit && start_data.size() < n; i++) @(negedge clk);
        @(negedge clk);
    endtask

    int fall_x;
    int mark;

    initial begin
        #5 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 2'b00);
        check("rst_active", active, 2'b00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_err_to", err_to, 1'b0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // inter-frame gap on the GAP_CYC=100 instance
        b_en = 1'b1;
        for (int i = 0; i < 1000 && b_acc.size() < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("gap_accepts", b_acc.size(), 3);
        check("gap_start_lat", b_start_cyc[0] - b_acc[0], 1);
        check("gap_data", b_start_data[0], 8'h77);
        check("gap_spacing1", b_acc[1] - b_fall_log[0], 101);
        check("gap_spacing2", b_acc[2] - b_fall_log[1], 101);

        // round robin with both requesters valid
        clear_logs();
        busy_en = 1'b1; busy_dly = 3; busy_len = 20;
        q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h22}); q1.push_back({1'b1, 8'h22});
        wait_starts(4, 600);
        repeat (40) @(negedge clk);
        check("rr_count", start_data.size(), 4);
        check("rr_byte0", start_data[0], 8'h11);
        check("rr_byte1", start_data[1], 8'h22);
        check("rr_byte2", start_data[2], 8'h11);
        check("rr_byte3", start_data[3], 8'h22);

        // packet lock, including an owner that stalls mid-packet
        clear_logs();
        q0.push_back({1'b0, 8'hA0});
        q1.push_back({1'b1, 8'hB0});
        repeat (100) @(negedge clk);
        check("lock_hold_count", start_data.size(), 1);
        check("lock_hold_active", active, 2'b01);
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
        wait_starts(4, 600);
        repeat (40) @(negedge clk);
        check("lock_byte0", start_data[0], 8'hA0);
        check("lock_byte1", start_data[1], 8'hA1);
        check("lock_byte2", start_data[2], 8'hA2);
        check("lock_byte3", start_data[3], 8'hB0);

        // single byte with a full-length frame
        clear_logs();
        busy_len = 4774;
        q0.push_back({1'b1, 8'h55});
        wait_starts(1, 50);
        check("single_ready", acc_vec[0], 2'b01);
        check("single_start_lat", start_cyc[0] - acc_cyc[0], 1);
        check("single_data", start_data[0], 8'h55);
        fall_x = start_cyc[0] + 3 + 4774;
        for (int i = 0; i < 6000 && cyc < fall_x; i++) @(negedge clk);
        check("single_active_busy", active, 2'b01);
        check("single_txdata_hold", tx_data, 8'h55);
        @(negedge clk);
        check("single_active_clear", active, 2'b00);

        // pointer advanced past requester 0, so requester 1 wins the tie
        busy_len = 20;
        repeat (5) @(negedge clk);
        clear_logs();
        q0.push_back({1'b1, 8'h66});
        q1.push_back({1'b1, 8'h77});
        wait_starts(2, 200);
        repeat (40) @(negedge clk);
        check("ptr_first", start_data[0], 8'h77);
        check("ptr_second", start_data[1], 8'h66);
        check("no_err_before_to", err_total, 0);

        // busy timeout: transmitter never answers
        clear_logs();
        busy_en = 1'b0;
        q1.push_back({1'b0, 8'hD0}); q1.push_back({1'b1, 8'hD1});
        q0.push_back({1'b1, 8'hC0});
        for (int i = 0; i < 400 && err_cyc.size() < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("to_err_count", err_cyc.size(), 3);
        check("to_latency", err_cyc[0] - start_cyc[0], 17);
        check("to_active", err_active[0], 2'b00);
        check("to_next_cycle", acc_cyc[1], err_cyc[0]);
        check("to_next_vec", acc_vec[1], 2'b01);
        check("to_byte0", start_data[0], 8'hD0);
        check("to_byte1", start_data[1], 8'hC0);
        check("to_byte2", start_data[2], 8'hD1);
        busy_en = 1'b1;

        // reset while the frame is in flight
        clear_logs();
        busy_len = 200;
        q0.push_back({1'b1, 8'hE5});
        wait_starts(1, 50);
        mark = start_cyc[0] + 20;
        for (int i = 0; i < 100 && cyc < mark; i++) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 2'b00);
        check("mid_rst_active", active, 2'b00);
        check("mid_rst_tx_start", tx_start, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_err_to", err_to, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_rst_no_restart", start_data.size(), 1);
        q0.push_back({1'b1, 8'h3C});
        wait_starts(2, 50);
        check("mid_rst_new_byte", start_data[1], 8'h3C);

        check("txdata_stable", bad_txd, 0);
        check("ready_onehot", bad_ready, 0);
        check("gap_no_err", b_err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
